// File: rtl/usb_tx_serializer_if.sv
// Packet hand-off and line-drive signals between the packet compiler and the USB TX serializer.
// master: packet compiler side (drives copy_signal/packet, observes line and status).
// slave : serializer side (consumes copy_signal/packet, drives dp/dm and status pulses).
interface usb_tx_serializer_if;
    logic         copy_signal;        // one-cycle strobe: packet valid, start transmission
    logic [543:0] packet_TX;          // compiled packet, bit 0 sent first
    logic [9:0]   packet_counter_TX;  // number of valid packet bits
    logic         dp_out;             // D+ drive
    logic         dm_out;             // D- drive
    logic         tx_busy;            // high from accepted copy through end of EOP
    logic         tx_done;            // one-cycle pulse when EOP finishes
    logic         tx_overrun;         // one-cycle pulse when copy arrives while busy

    modport master (
        output copy_signal, packet_TX, packet_counter_TX,
        input  dp_out, dm_out, tx_busy, tx_done, tx_overrun
    );

    modport slave (
        input  copy_signal, packet_TX, packet_counter_TX,
        output dp_out, dm_out, tx_busy, tx_done, tx_overrun
    );
endinterface

// File: rtl/usb_tx_serializer.sv
// USB full-speed TX serializer: NRZI encoding, bit stuffing after six ones, SE0/SE0/J end-of-packet.
// Latency: first bit on the line the cycle after copy_signal; each symbol held CLKS_PER_BIT cycles.
// Backpressure: none; copy_signal while busy (or in the DONE cycle) is dropped and flagged on tx_overrun.
// Ports: clk, n_rst (async active-low), bus (usb_tx_serializer_if.slave).
module usb_tx_serializer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    usb_tx_serializer_if.slave    bus
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [9:0]    MAX_LEN  = 10'd544;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND    = 3'd1,
        STUFF   = 3'd2,
        EOP_SE0 = 3'd3,
        EOP_J   = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t         state_q;
    logic [543:0]   shift_q;   // remaining packet bits, next bit in [0]
    logic [9:0]     len_q;     // latched (clamped) bit length
    logic [9:0]     pos_q;     // number of packet bits already put on the line
    logic [2:0]     ones_q;    // consecutive ones on the line
    logic [CW-1:0]  cnt_q;     // bit-period counter
    logic           nrzi_q;    // current NRZI level, 1 = J
    logic           se0_q;     // second SE0 bit period flag
    logic           dp_q, dm_q, busy_q, done_q, ovr_q;

    // Next packet bit and its encoding. On load the bit comes straight from
    // the bus and NRZI/ones history starts fresh from J.
    logic           bit_d;
    logic           lvl_d;
    logic [2:0]     ones_d;
    logic [9:0]     len_d;
    logic           last_cyc;

    always_comb begin
        bit_d  = shift_q[0];
        lvl_d  = nrzi_q;
        ones_d = 3'd0;
        if (state_q == IDLE) begin
            bit_d  = bus.packet_TX[0];
            lvl_d  = bit_d ? 1'b1 : 1'b0;
            ones_d = bit_d ? 3'd1 : 3'd0;
        end else begin
            lvl_d  = bit_d ? nrzi_q : ~nrzi_q;
            ones_d = bit_d ? (ones_q + 3'd1) : 3'd0;
        end
        len_d    = (bus.packet_counter_TX > MAX_LEN) ? MAX_LEN : bus.packet_counter_TX;
        last_cyc = (cnt_q == CNT_LAST);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            len_q   <= '0;
            pos_q   <= '0;
            ones_q  <= '0;
            cnt_q   <= '0;
            nrzi_q  <= 1'b1;
            se0_q   <= 1'b0;
            dp_q    <= 1'b1;
            dm_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Anything other than IDLE (including DONE) counts as busy for a new request.
            ovr_q  <= bus.copy_signal && (state_q != IDLE);

            case (state_q)
                IDLE: begin
                    dp_q   <= 1'b1;
                    dm_q   <= 1'b0;
                    busy_q <= 1'b0;
                    if (bus.copy_signal) begin
                        busy_q <= 1'b1;
                        cnt_q  <= '0;
                        len_q  <= len_d;
                        se0_q  <= 1'b0;
                        if (len_d != 10'd0) begin
                            state_q <= SEND;
                            shift_q <= bus.packet_TX >> 1;
                            pos_q   <= 10'd1;
                            ones_q  <= ones_d;
                            nrzi_q  <= lvl_d;
                            dp_q    <= lvl_d;
                            dm_q    <= ~lvl_d;
                        end else begin
                            state_q <= EOP_SE0;
                            shift_q <= bus.packet_TX;
                            pos_q   <= '0;
                            ones_q  <= '0;
                            nrzi_q  <= 1'b1;
                            dp_q    <= 1'b0;
                            dm_q    <= 1'b0;
                        end
                    end
                end

                SEND, STUFF: begin
                    if (last_cyc) begin
                        cnt_q <= '0;
                        if (ones_q == 3'd6) begin
                            // Stuffed zero: toggle, consume no packet bit.
                            state_q <= STUFF;
                            ones_q  <= '0;
                            nrzi_q  <= ~nrzi_q;
                            dp_q    <= ~nrzi_q;
                            dm_q    <= nrzi_q;
                        end else if (pos_q < len_q) begin
                            state_q <= SEND;
                            shift_q <= shift_q >> 1;
                            pos_q   <= pos_q + 10'd1;
                            ones_q  <= ones_d;
                            nrzi_q  <= lvl_d;
                            dp_q    <= lvl_d;
                            dm_q    <= ~lvl_d;
                        end else begin
                            state_q <= EOP_SE0;
                            se0_q   <= 1'b0;
                            ones_q  <= '0;
                            dp_q    <= 1'b0;
                            dm_q    <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                EOP_SE0: begin
                    if (last_cyc) begin
                        cnt_q <= '0;
                        if (se0_q) begin
                            state_q <= EOP_J;
                            nrzi_q  <= 1'b1;
                            dp_q    <= 1'b1;
                            dm_q    <= 1'b0;
                        end else begin
                            se0_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                EOP_J: begin
                    if (last_cyc) begin
                        cnt_q   <= '0;
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        dp_q    <= 1'b1;
                        dm_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                    dp_q    <= 1'b1;
                    dm_q    <= 1'b0;
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    dp_q    <= 1'b1;
                    dm_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dp_out     = dp_q;
    assign bus.dm_out     = dm_q;
    assign bus.tx_busy    = busy_q;
    assign bus.tx_done    = done_q;
    assign bus.tx_overrun = ovr_q;

endmodule

// File: doc/usb_tx_serializer.md
USB_TX_SERIALIZER -- requirements
Module: usb_tx_serializer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, meaning clk cycles per USB bit time (48 MHz clk -> 12 Mb/s).
REQ-002 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-003 SHALL have port n_rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port copy_signal  input  1  one-cycle strobe: compiled packet valid, start transmission.
REQ-005 SHALL have port packet_TX  input  544  compiled packet; bit 0 transmitted first.
REQ-006 SHALL have port packet_counter_TX  input  10  number of valid packet bits.
REQ-007 SHALL have port dp_out  output  1  D+ line drive.
REQ-008 SHALL have port dm_out  output  1  D- line drive.
REQ-009 SHALL have port tx_busy  output  1  high from accepted copy_signal through end of EOP.
REQ-010 SHALL have port tx_done  output  1  one-cycle pulse when EOP finishes.
REQ-011 SHALL have port tx_overrun  output  1  one-cycle pulse when copy_signal arrives while busy.

Function
REQ-012 SHALL implement states IDLE, SEND, STUFF, EOP_SE0, EOP_J, DONE.
REQ-013 IDLE: line drives J (dp_out=1, dm_out=0); tx_busy=0.
REQ-014 copy_signal high in IDLE SHALL, on that edge, latch packet_TX into a 544-bit shift register and packet_counter_TX into a bit-length register, set tx_busy=1, enter SEND (length>0) or EOP_SE0 (length=0).
REQ-015 Latched length SHALL clamp to 544 when packet_counter_TX > 544.
REQ-016 First bit SHALL appear on the line the cycle after copy_signal is sampled; every line symbol SHALL be held exactly CLKS_PER_BIT cycles by a bit-period counter.
REQ-017 SEND SHALL transmit latched bits in ascending index order, one per bit period, until length bits are sent.
REQ-018 NRZI: data 0 -> toggle J/K; data 1 -> hold current level; NRZI state SHALL initialise to J on load.
REQ-019 A ones counter (3 bits) SHALL increment on each transmitted 1 and clear on each transmitted 0 or stuffed bit.
REQ-020 After the sixth consecutive 1, SHALL enter STUFF for one bit period transmitting a 0 (toggle), not consuming a packet bit, then resume SEND.
REQ-021 If the sixth consecutive 1 is the last packet bit, the stuffed bit SHALL still be sent before EOP_SE0.
REQ-022 EOP_SE0 SHALL drive dp_out=0, dm_out=0 for 2 bit periods; EOP_J SHALL drive J for 1 bit period.
REQ-023 DONE SHALL last one cycle: tx_done=1, tx_busy=0, drive J, return to IDLE.
REQ-024 copy_signal while tx_busy=1 SHALL be ignored (no latch, no state change) and pulse tx_overrun the next cycle.
REQ-025 copy_signal coincident with DONE SHALL be treated as busy (overrun).
REQ-026 Bit-position counter SHALL be 10 bits wide; no wrap beyond latched length.

Reset
REQ-027 n_rst low SHALL asynchronously force IDLE, dp_out=1, dm_out=0, tx_busy=0, tx_done=0, tx_overrun=0, shift/length/ones/bit-period counters to 0.
REQ-028 Reset mid-packet SHALL abort transmission immediately with no EOP; line returns to J.

Verification
REQ-029 ACK: packet_TX[15:0]=16'h0201, length 16, CLKS_PER_BIT=4 -> 64 data cycles, 8 SE0 cycles, 4 J cycles, tx_done pulse at cycle 77 after copy; tx_busy high cycles 1-76.
REQ-030 Stuffing: packet_TX[15:0]=16'hFF01, length 16 -> 17 bit periods before SE0; line holds level 6 bit periods after bit 8, then toggles for stuffed 0.
REQ-031 Trailing stuff: length 14, bits 8-13 all 1 -> stuffed bit sent after bit 13, then SE0.
REQ-032 Length 0 -> SE0 immediately on cycle 1 for 8 cycles, J 4 cycles, tx_done.
REQ-033 copy_signal pulsed at cycle 20 of an active packet -> tx_overrun pulse at cycle 21; transmitted bits unchanged.
REQ-034 n_rst asserted at cycle 30 of a 16-bit packet -> dp_out=1, dm_out=0, tx_busy=0 same cycle; next copy_signal transmits normally.
